prog_freq_serial_out: RTL and testbench

PROG_FREQ_SERIAL_OUT -- requirements
Module: prog_freq_serial_out

---
 rtl/prog_freq_serial_out.sv | 152 +++++++++++++++
 tb/tb_prog_freq_serial_out.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/prog_freq_serial_out.sv
// Programmable-rate serialiser: shifts a latched word out one bit at a time, each bit
// held (div+1)*TICK_PER_BIT clocks, with selectable bit order and idle-line behaviour.
module prog_freq_serial_out #(
  parameter int unsigned DATA_BIT     = 32,
  parameter int unsigned TICK_PER_BIT = 16,
  parameter int unsigned DIV_BIT      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [DIV_BIT-1:0]  i_div,
  input  logic                i_msb_first,
  input  logic [1:0]          i_idle_mode,
  input  logic [DATA_BIT-1:0] i_data,
  output logic                o_busy,
  output logic                o_bit_tick,
  output logic                o_data,
  output logic                o_done_tick
);

  localparam int unsigned BIT_W  = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
  localparam int unsigned TICK_W = $clog2(TICK_PER_BIT + 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BIT - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICK_PER_BIT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state;
  logic [DATA_BIT-1:0] word_q;
  logic [DIV_BIT-1:0]  div_q;
  logic                msb_q;
  logic [1:0]          mode_q;
  logic                stop_pend;
  logic [DIV_BIT-1:0]  div_cnt;
  logic [TICK_W-1:0]   tick_cnt;
  logic [BIT_W-1:0]    bit_cnt;

  logic                cur_last;
  logic                word_end;
  logic                stop_now;
  logic                go_run;
  logic                reload;
  logic                stay;
  logic                busy_n;
  logic                last_n;
  logic                idle_bit;
  logic [DIV_BIT-1:0]  div_ref_n;
  logic [DIV_BIT-1:0]  div_n;
  logic [TICK_W-1:0]   tick_n;
  logic [BIT_W-1:0]    bit_n;

  // Select the bit for serial position idx according to the bit order.
  function automatic logic pick_bit(input logic [DATA_BIT-1:0] word,
                                    input logic                msb,
                                    input logic [BIT_W-1:0]    idx);
    logic [BIT_W-1:0] pos;
    pos = msb ? (LAST_BIT - idx) : idx;
    return word[pos];
  endfunction

  // Counter advance and look-ahead of next cycle's tick flags, so the pulses can be registered.
  always_comb begin
    cur_last  = (div_cnt >= div_q) && (tick_cnt >= LAST_TICK);
    word_end  = cur_last && (bit_cnt >= LAST_BIT);
    stop_now  = stop_pend | i_stop;
    go_run    = (state == IDLE) && i_start && !i_stop;
    reload    = (state == RUN) && word_end && (mode_q == 2'b11) && !stop_now;
    stay      = (state == RUN) && !word_end;
    busy_n    = go_run | reload | stay;
    div_ref_n = go_run ? i_div : div_q;
    div_n     = '0;
    tick_n    = '0;
    bit_n     = '0;
    if (stay) begin
      if (cur_last) begin
        bit_n = bit_cnt + BIT_W'(1);
      end else begin
        bit_n = bit_cnt;
        if (div_cnt >= div_q) begin
          tick_n = tick_cnt + TICK_W'(1);
        end else begin
          tick_n = tick_cnt;
          div_n  = div_cnt + DIV_BIT'(1);
        end
      end
    end
    last_n = busy_n && (div_n >= div_ref_n) && (tick_n >= LAST_TICK);
    case (mode_q)
      2'b00:   idle_bit = 1'b0;
      2'b01:   idle_bit = 1'b1;
      2'b10:   idle_bit = o_data;
      default: idle_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      word_q      <= '0;
      div_q       <= '0;
      msb_q       <= 1'b0;
      mode_q      <= '0;
      stop_pend   <= 1'b0;
      div_cnt     <= '0;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      o_busy      <= 1'b0;
      o_bit_tick  <= 1'b0;
      o_done_tick <= 1'b0;
      o_data      <= 1'b0;
    end else begin
      div_cnt     <= div_n;
      tick_cnt    <= tick_n;
      bit_cnt     <= bit_n;
      o_busy      <= busy_n;
      o_bit_tick  <= last_n;
      o_done_tick <= last_n && (bit_n >= LAST_BIT);
      case (state)
        IDLE: begin
          stop_pend <= 1'b0;
          if (go_run) begin
            state  <= RUN;
            word_q <= i_data;
            div_q  <= i_div;
            msb_q  <= i_msb_first;
            mode_q <= i_idle_mode;
            o_data <= pick_bit(i_data, i_msb_first, '0);
          end
        end
        RUN: begin
          if (i_stop) stop_pend <= 1'b1;
          if (word_end) begin
            if (reload) begin
              o_data <= pick_bit(word_q, msb_q, '0);
            end else begin
              state     <= IDLE;
              stop_pend <= 1'b0;
              o_data    <= idle_bit;
            end
          end else if (cur_last) begin
            o_data <= pick_bit(word_q, msb_q, bit_n);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_freq_serial_out.sv
// Bench for prog_freq_serial_out: directed scenarios plus random words, each checked
// cycle-by-cycle against a per-cycle expectation derived from the bit timing rules.
module tb_prog_freq_serial_out;

  localparam int unsigned DB  = 8;
  localparam int unsigned TPB = 2;
  localparam int unsigned DVB = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_start = 1'b0;
  logic           i_stop = 1'b0;
  logic [DVB-1:0] i_div = '0;
  logic           i_msb_first = 1'b0;
  logic [1:0]     i_idle_mode = '0;
  logic [DB-1:0]  i_data = '0;
  logic           o_busy;
  logic           o_bit_tick;
  logic           o_data;
  logic           o_done_tick;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prog_freq_serial_out #(
    .DATA_BIT    (DB),
    .TICK_PER_BIT(TPB),
    .DIV_BIT     (DVB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_div      (i_div),
    .i_msb_first(i_msb_first),
    .i_idle_mode(i_idle_mode),
    .i_data     (i_data),
    .o_busy     (o_busy),
    .o_bit_tick (o_bit_tick),
    .o_data     (o_data),
    .o_done_tick(o_done_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_data);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_bit_tick"}, 32'(o_bit_tick), 32'd0);
    chk({tag, "_done_tick"}, 32'(o_done_tick), 32'd0);
    chk({tag, "_data"}, 32'(o_data), 32'(exp_data));
  endtask

  // Called just after a falling edge. Starts a transfer on the next rising edge and
  // checks every cycle; stop/start/reset pulses are applied at the given cycle numbers
  // (counted from 1 = first cycle with o_busy high; 0 = never).
  task automatic send(input logic [7:0] d, input logic [3:0] dv, input logic msb,
                      input logic [1:0] mode, input int words, input int stop_cyc,
                      input int start_cyc, input int abort_cyc);
    int   len;
    int   per_word;
    int   total;
    int   cw;
    int   k;
    logic [2:0] idx;
    logic exp_bit;
    logic idle_exp;
    len      = (int'(dv) + 1) * int'(TPB);
    per_word = 8 * len;
    total    = words * per_word;
    i_data      = d;
    i_div       = dv;
    i_msb_first = msb;
    i_idle_mode = mode;
    i_start     = 1'b1;
    i_stop      = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 1; c <= total; c++) begin
      cw  = (c - 1) % per_word + 1;
      k   = (cw - 1) / len;
      idx = msb ? 3'(7 - k) : 3'(k);
      exp_bit = d[idx];
      chk("run_busy", 32'(o_busy), 32'd1);
      chk("run_data", 32'(o_data), 32'(exp_bit));
      chk("run_bit_tick", 32'(o_bit_tick), 32'((cw % len) == 0));
      chk("run_done_tick", 32'(o_done_tick), 32'(cw == per_word));
      // Scramble the live inputs: the latched copies must carry the transfer.
      i_data      = 8'($urandom);
      i_div       = 4'($urandom);
      i_msb_first = 1'($urandom);
      i_idle_mode = 2'($urandom);
      i_start     = (c == start_cyc);
      i_stop      = (c == stop_cyc);
      if (c == abort_cyc) rst_n = 1'b0;
      @(negedge clk);
      if (c == abort_cyc) begin
        chk_idle("abort", 1'b0);
        rst_n   = 1'b1;
        i_start = 1'b0;
        i_stop  = 1'b0;
        return;
      end
    end
    i_start = 1'b0;
    i_stop  = 1'b0;
    case (mode)
      2'b01:   idle_exp = 1'b1;
      2'b10:   idle_exp = msb ? d[0] : d[7];
      default: idle_exp = 1'b0;
    endcase
    for (int j = 0; j < 3; j++) begin
      chk_idle("idle", idle_exp);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic [3:0] rdv;
    logic [1:0] rmode;
    logic       rmsb;
    int         rwords;
    int         rper;
    int         rstop;
    int         rstart;

    // Reset with a start request pending: reset must win.
    i_start = 1'b1;
    i_data  = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      chk_idle("reset", 1'b0);
    end
    rst_n = 1'b1;

    // LSB first, div=1, idle low; start on the first edge after release.
    send(8'hA5, 4'd1, 1'b0, 2'b00, 1, 0, 0, 0);
    // MSB first, div=0, keep last bit.
    send(8'h81, 4'd0, 1'b1, 2'b10, 1, 0, 0, 0);
    // Repeat mode, stop requested in the middle of word 2.
    send(8'h0F, 4'd0, 1'b0, 2'b11, 2, 16 + 5, 0, 0);
    // Start during RUN ignored.
    send(8'h3C, 4'd1, 1'b1, 2'b00, 1, 0, 5, 0);
    // Start together with stop in IDLE stays idle.
    i_start = 1'b1;
    i_stop  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_idle("start_stop", 1'b0);
    end
    i_start = 1'b0;
    i_stop  = 1'b0;
    @(negedge clk);
    // Reset at clock 10 of a div=3 word, then a full word right after release.
    send(8'h96, 4'd3, 1'b0, 2'b01, 1, 0, 0, 10);
    send(8'h96, 4'd3, 1'b0, 2'b01, 1, 0, 0, 0);
    // Maximum divider.
    send(8'h5A, 4'd15, 1'b1, 2'b01, 1, 0, 0, 0);

    // Random words.
    for (int n = 0; n < 14; n++) begin
      rd     = 8'($urandom);
      rdv    = 4'($urandom_range(0, 3));
      rmsb   = 1'($urandom);
      rmode  = 2'($urandom);
      rwords = (rmode == 2'b11) ? int'($urandom_range(1, 3)) : 1;
      rper   = 8 * (int'(rdv) + 1) * int'(TPB);
      rstop  = (rmode == 2'b11) ? (rwords - 1) * rper + int'($urandom_range(1, rper - 1)) : 0;
      rstart = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, rper)) : 0;
      send(rd, rdv, rmsb, rmode, rwords, rstop, rstart, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
